vending_change_dispenser: RTL and testbench

VENDING_CHANGE_DISPENSER -- requirements
Module: vending_change_dispenser

---
 rtl/vending_change_dispenser.sv | 105 ++++++++++
 tb/tb_vending_change_dispenser.sv | 220 ++++++++++++++++++++++
 2 files changed

// File: rtl/vending_change_dispenser.sv
// Coin-operated vending controller: accumulates credit, vends at PRICE and
// pays any remainder (or a cancelled credit) back as greedy 10/5 change.
module vending_change_dispenser #(
    parameter int PRICE = 4
) (
    input  logic       i_clk,
    input  logic       i_rst,
    input  logic       i_coin_5,
    input  logic       i_coin_10,
    input  logic       i_coin_20,
    input  logic       i_cancel,
    input  logic       i_change_ready,
    output logic [3:0] o_credit,
    output logic       o_vend,
    output logic       o_change_valid,
    output logic       o_change_coin,
    output logic       o_coin_reject,
    output logic       o_busy
);

    typedef enum logic [1:0] {IDLE, VEND, CHANGE} state_t;

    localparam logic [3:0] PRICE_U = 4'(PRICE);

    state_t     state_q, state_d;
    logic [3:0] credit_q, credit_d;
    logic       reject_q, reject_d;

    logic [2:0] coin_value;
    logic [3:0] credit_sum;
    logic [3:0] change_step;
    logic [3:0] change_left;
    logic       any_coin;

    // Credit stays below PRICE in IDLE, so credit + 7 never exceeds 14.
    always_comb begin
        coin_value  = {2'b00, i_coin_5} + {1'b0, i_coin_10, 1'b0} + {i_coin_20, 2'b00};
        credit_sum  = credit_q + {1'b0, coin_value};
        change_step = (credit_q >= 4'd2) ? 4'd2 : 4'd1;
        change_left = credit_q - change_step;
        any_coin    = i_coin_5 | i_coin_10 | i_coin_20;
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q  <= IDLE;
            credit_q <= 4'd0;
            reject_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            credit_q <= credit_d;
            reject_q <= reject_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (credit_sum >= PRICE_U) begin
                    state_d = VEND;
                end else if (i_cancel && (credit_sum != 4'd0)) begin
                    state_d = CHANGE;
                end
            end
            VEND:    state_d = (credit_q != PRICE_U) ? CHANGE : IDLE;
            CHANGE: begin
                if (i_change_ready && (change_left == 4'd0)) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Coins arriving while busy never touch credit; they are bounced back.
    always_comb begin
        credit_d = credit_q;
        reject_d = 1'b0;
        case (state_q)
            IDLE:   credit_d = credit_sum;
            VEND: begin
                credit_d = credit_q - PRICE_U;
                reject_d = any_coin;
            end
            CHANGE: begin
                if (i_change_ready) begin
                    credit_d = change_left;
                end
                reject_d = any_coin;
            end
            default: credit_d = 4'd0;
        endcase
    end

    always_comb begin
        o_credit       = credit_q;
        o_vend         = (state_q == VEND);
        o_change_valid = (state_q == CHANGE);
        o_change_coin  = (state_q == CHANGE) && (credit_q >= 4'd2);
        o_coin_reject  = reject_q;
        o_busy         = (state_q != IDLE);
    end

endmodule

// File: tb/tb_vending_change_dispenser.sv
// Bench for vending_change_dispenser: a credit-arithmetic model checked every
// cycle, plus literal expectations at key points of each directed scenario.
module tb_vending_change_dispenser;

    localparam int PRICE = 4;

    logic       i_clk;
    logic       i_rst;
    logic       i_coin_5;
    logic       i_coin_10;
    logic       i_coin_20;
    logic       i_cancel;
    logic       i_change_ready;
    logic [3:0] o_credit;
    logic       o_vend;
    logic       o_change_valid;
    logic       o_change_coin;
    logic       o_coin_reject;
    logic       o_busy;

    int checks = 0;
    int errors = 0;

    int m_credit   = 0;
    bit m_vending  = 1'b0;
    bit m_paying   = 1'b0;
    bit m_reject   = 1'b0;
    bit model_live = 1'b0;

    vending_change_dispenser #(.PRICE(PRICE)) dut (
        .i_clk          (i_clk),
        .i_rst          (i_rst),
        .i_coin_5       (i_coin_5),
        .i_coin_10      (i_coin_10),
        .i_coin_20      (i_coin_20),
        .i_cancel       (i_cancel),
        .i_change_ready (i_change_ready),
        .o_credit       (o_credit),
        .o_vend         (o_vend),
        .o_change_valid (o_change_valid),
        .o_change_coin  (o_change_coin),
        .o_coin_reject  (o_coin_reject),
        .o_busy         (o_busy)
    );

    initial i_clk = 1'b0;
    always #5 i_clk = ~i_clk;

    task automatic compare(input string name, input int actual, input int expected);
        checks++;
        if (actual != expected) begin
            errors++;
            $display("[TB] FAIL %s at %0t: got %0d expected %0d", name, $time, actual, expected);
        end
    endtask

    // Model: credit is a plain integer; a sale takes one cycle, then change is
    // paid out in 10s while at least 2 units remain, else a single 5.
    always @(posedge i_clk) begin
        int value;
        int total;
        if (i_rst) begin
            m_credit   <= 0;
            m_vending  <= 1'b0;
            m_paying   <= 1'b0;
            m_reject   <= 1'b0;
            model_live <= 1'b1;
        end else begin
            value = int'(i_coin_5) + 2 * int'(i_coin_10) + 4 * int'(i_coin_20);
            m_reject <= (m_vending || m_paying) && (value > 0);
            if (m_vending) begin
                total = m_credit - PRICE;
                m_credit  <= total;
                m_vending <= 1'b0;
                m_paying  <= (total > 0);
            end else if (m_paying) begin
                if (i_change_ready) begin
                    total = m_credit - ((m_credit >= 2) ? 2 : 1);
                    m_credit <= total;
                    m_paying <= (total > 0);
                end
            end else begin
                total = m_credit + value;
                m_credit <= total;
                if (total >= PRICE) begin
                    m_vending <= 1'b1;
                end else if (i_cancel && (total > 0)) begin
                    m_paying <= 1'b1;
                end
            end
        end
    end

    always @(negedge i_clk) begin
        if (model_live) begin
            compare("model_credit", int'(o_credit), m_credit);
            compare("model_vend", int'(o_vend), int'(m_vending));
            compare("model_valid", int'(o_change_valid), int'(m_paying));
            compare("model_coin", int'(o_change_coin), int'(m_paying && (m_credit >= 2)));
            compare("model_reject", int'(o_coin_reject), int'(m_reject));
            compare("model_busy", int'(o_busy), int'(m_vending || m_paying));
        end
    end

    // Drives one cycle of inputs just after a rising edge and returns #1
    // after the edge that sampled them, with the pulse inputs cleared.
    task automatic applyStimulus(input bit c5, input bit c10, input bit c20,
                                 input bit cancel, input bit ready);
        i_coin_5       = c5;
        i_coin_10      = c10;
        i_coin_20      = c20;
        i_cancel       = cancel;
        i_change_ready = ready;
        @(posedge i_clk);
        #1;
        i_coin_5  = 1'b0;
        i_coin_10 = 1'b0;
        i_coin_20 = 1'b0;
        i_cancel  = 1'b0;
    endtask

    task automatic checkOutput(input string name, input int credit, input bit vend,
                               input bit valid, input bit coin, input bit reject,
                               input bit busy);
        compare({name, "_credit"}, int'(o_credit), credit);
        compare({name, "_vend"}, int'(o_vend), int'(vend));
        compare({name, "_valid"}, int'(o_change_valid), int'(valid));
        compare({name, "_coin"}, int'(o_change_coin), int'(coin));
        compare({name, "_reject"}, int'(o_coin_reject), int'(reject));
        compare({name, "_busy"}, int'(o_busy), int'(busy));
        compare({name, "_mcredit"}, m_credit, credit);
    endtask

    initial begin
        i_rst          = 1'b1;
        i_coin_5       = 1'b0;
        i_coin_10      = 1'b0;
        i_coin_20      = 1'b0;
        i_cancel       = 1'b0;
        i_change_ready = 1'b0;
        @(posedge i_clk);
        @(posedge i_clk);
        #1;
        checkOutput("reset", 0, 0, 0, 0, 0, 0);
        i_rst = 1'b0;

        // 5, 5, 10 reaches the price exactly: vend with no change
        applyStimulus(1, 0, 0, 0, 0); checkOutput("exact_c1", 1, 0, 0, 0, 0, 0);
        applyStimulus(1, 0, 0, 0, 0); checkOutput("exact_c2", 2, 0, 0, 0, 0, 0);
        applyStimulus(0, 1, 0, 0, 0); checkOutput("exact_vend", 4, 1, 0, 0, 0, 1);
        applyStimulus(0, 0, 0, 0, 0); checkOutput("exact_idle", 0, 0, 0, 0, 0, 0);

        // 10 then 20: remainder 2 paid as one 10
        applyStimulus(0, 1, 0, 0, 0); checkOutput("ch2_c1", 2, 0, 0, 0, 0, 0);
        applyStimulus(0, 0, 1, 0, 0); checkOutput("ch2_vend", 6, 1, 0, 0, 0, 1);
        applyStimulus(0, 0, 0, 0, 0); checkOutput("ch2_offer", 2, 0, 1, 1, 0, 1);
        applyStimulus(0, 0, 0, 0, 1); checkOutput("ch2_done", 0, 0, 0, 0, 0, 0);

        // 5, 10, 20: remainder 3 with the hopper stalling for 3 cycles
        applyStimulus(1, 0, 0, 0, 0);
        applyStimulus(0, 1, 0, 0, 0); checkOutput("ch3_c2", 3, 0, 0, 0, 0, 0);
        applyStimulus(0, 0, 1, 0, 0); checkOutput("ch3_vend", 7, 1, 0, 0, 0, 1);
        applyStimulus(0, 0, 0, 0, 0); checkOutput("ch3_offer", 3, 0, 1, 1, 0, 1);
        for (int i = 0; i < 3; i++) begin
            applyStimulus(0, 0, 0, 0, 0); checkOutput("ch3_stall", 3, 0, 1, 1, 0, 1);
        end
        applyStimulus(0, 0, 0, 0, 1); checkOutput("ch3_five", 1, 0, 1, 0, 0, 1);
        applyStimulus(0, 0, 0, 0, 1); checkOutput("ch3_done", 0, 0, 0, 0, 0, 0);

        // cancel refunds 10 then 5; cancel at zero credit does nothing
        applyStimulus(1, 0, 0, 0, 0);
        applyStimulus(0, 1, 0, 0, 0);
        applyStimulus(0, 0, 0, 1, 0); checkOutput("cancel_offer", 3, 0, 1, 1, 0, 1);
        applyStimulus(0, 0, 0, 0, 1); checkOutput("cancel_five", 1, 0, 1, 0, 0, 1);
        applyStimulus(0, 0, 0, 0, 1); checkOutput("cancel_done", 0, 0, 0, 0, 0, 0);
        applyStimulus(0, 0, 0, 1, 1); checkOutput("cancel_zero", 0, 0, 0, 0, 0, 0);
        applyStimulus(0, 0, 1, 1, 1); checkOutput("cancel_vend", 4, 1, 0, 0, 0, 1);
        applyStimulus(0, 0, 0, 0, 1); checkOutput("cancel_idle", 0, 0, 0, 0, 0, 0);

        // coins while busy are rejected and leave credit alone
        applyStimulus(0, 1, 0, 0, 0);
        applyStimulus(0, 0, 1, 0, 0); checkOutput("rej_vend", 6, 1, 0, 0, 0, 1);
        applyStimulus(0, 1, 0, 0, 0); checkOutput("rej_in_vend", 2, 0, 1, 1, 1, 1);
        applyStimulus(0, 1, 0, 0, 0); checkOutput("rej_in_change", 2, 0, 1, 1, 1, 1);
        applyStimulus(0, 0, 0, 1, 0); checkOutput("rej_clear", 2, 0, 1, 1, 0, 1);
        applyStimulus(0, 0, 0, 0, 1); checkOutput("rej_done", 0, 0, 0, 0, 0, 0);

        // reset mid-change discards the outstanding credit
        applyStimulus(1, 0, 0, 0, 0);
        applyStimulus(0, 1, 0, 0, 0);
        applyStimulus(0, 0, 1, 0, 0);
        applyStimulus(0, 0, 0, 0, 0); checkOutput("rst_offer", 3, 0, 1, 1, 0, 1);
        i_rst = 1'b1;
        applyStimulus(0, 0, 0, 0, 1); checkOutput("rst_abort", 0, 0, 0, 0, 0, 0);
        i_rst = 1'b0;
        applyStimulus(0, 0, 1, 0, 0); checkOutput("rst_vend", 4, 1, 0, 0, 0, 1);
        applyStimulus(0, 0, 0, 0, 0); checkOutput("rst_idle", 0, 0, 0, 0, 0, 0);

        // maximum credit: 3 units plus all coins at once gives PRICE+6
        applyStimulus(0, 1, 0, 0, 0);
        applyStimulus(1, 0, 0, 0, 0);
        applyStimulus(1, 1, 1, 0, 0); checkOutput("max_vend", 10, 1, 0, 0, 0, 1);
        applyStimulus(0, 0, 0, 0, 1); checkOutput("max_offer", 6, 0, 1, 1, 0, 1);
        applyStimulus(0, 0, 0, 0, 1); checkOutput("max_pay1", 4, 0, 1, 1, 0, 1);
        applyStimulus(0, 0, 0, 0, 1); checkOutput("max_pay2", 2, 0, 1, 1, 0, 1);
        applyStimulus(0, 0, 0, 0, 1); checkOutput("max_done", 0, 0, 0, 0, 0, 0);

        // all coins together from zero: vend with remainder 3
        applyStimulus(1, 1, 1, 0, 0); checkOutput("all_vend", 7, 1, 0, 0, 0, 1);
        applyStimulus(0, 0, 0, 0, 1); checkOutput("all_offer", 3, 0, 1, 1, 0, 1);
        applyStimulus(0, 0, 0, 0, 1);
        applyStimulus(0, 0, 0, 0, 1); checkOutput("all_done", 0, 0, 0, 0, 0, 0);

        @(negedge i_clk);
        #1;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
